// File: rtl/hl_bus_arbiter_if.sv
// Bundle of requester-side and adapter-side signals around hl_bus_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding logic (requesters plus the adapter host port).
interface hl_bus_arbiter_if #(
    parameter int NUM_REQ     = 3,
    parameter int WIDTH       = 32,
    parameter int MAX_BIT_POS = 31
);
    // Requester side
    logic [NUM_REQ-1:0]                   req_read_en;
    logic [NUM_REQ-1:0]                   req_write_en;
    logic [NUM_REQ*(MAX_BIT_POS+1)-1:0]   req_addr;
    logic [NUM_REQ*WIDTH-1:0]             req_data_in;
    logic [NUM_REQ-1:0]                   req_grant;
    logic [NUM_REQ-1:0]                   req_data_ready;
    logic [WIDTH-1:0]                     req_data_out;

    // Adapter host side
    logic                                 h_read_en;
    logic                                 h_write_en;
    logic [MAX_BIT_POS:0]                 h_addr;
    logic [WIDTH-1:0]                     h_data_in;
    logic                                 h_data_ready;
    logic [WIDTH-1:0]                     h_data_out;

    // Watchdog abort indication
    logic                                 arb_timeout;

    modport slave (
        input  req_read_en,
        input  req_write_en,
        input  req_addr,
        input  req_data_in,
        output req_grant,
        output req_data_ready,
        output req_data_out,
        output h_read_en,
        output h_write_en,
        output h_addr,
        output h_data_in,
        input  h_data_ready,
        input  h_data_out,
        output arb_timeout
    );

    modport master (
        output req_read_en,
        output req_write_en,
        output req_addr,
        output req_data_in,
        input  req_grant,
        input  req_data_ready,
        input  req_data_out,
        input  h_read_en,
        input  h_write_en,
        input  h_addr,
        input  h_data_in,
        output h_data_ready,
        output h_data_out,
        input  arb_timeout
    );
endinterface

// File: rtl/hl_bus_arbiter.sv
// hl_bus_arbiter: round-robin arbiter sharing the host port of the
// high-to-low clock adapter among NUM_REQ fast-domain requesters.
// One transaction at a time: IDLE -> BUSY (held until h_data_ready) ->
// RELEASE (completion pulse to the owner) -> IDLE.
// Optional watchdog: define HL_ARB_TIMEOUT_EN to abort a BUSY phase after
// TIMEOUT_CYCLES cycles, returning all-ones data and pulsing arb_timeout.
module hl_bus_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int WIDTH          = 32,
    parameter int MAX_BIT_POS    = 31,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk_h,
    input  logic               rst,
    hl_bus_arbiter_if.slave    bus
);

    localparam int AW    = MAX_BIT_POS + 1;
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [IDX_W-1:0]       last_reg, last_next;
    logic [NUM_REQ-1:0]     grant_reg, grant_next;
    logic [NUM_REQ-1:0]     data_ready_reg, data_ready_next;
    logic [WIDTH-1:0]       data_out_reg, data_out_next;
    logic                   h_read_en_reg, h_read_en_next;
    logic                   h_write_en_reg, h_write_en_next;
    logic [AW-1:0]          h_addr_reg, h_addr_next;
    logic [WIDTH-1:0]       h_data_in_reg, h_data_in_next;
    logic                   timeout_reg, timeout_next;

    // Unpacked per-requester views of the packed request buses
    logic [AW-1:0]          addr_arr  [NUM_REQ];
    logic [WIDTH-1:0]       wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]     pending;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.req_addr[gi*AW +: AW];
            assign wdata_arr[gi] = bus.req_data_in[gi*WIDTH +: WIDTH];
            assign pending[gi]   = bus.req_read_en[gi] | bus.req_write_en[gi];
        end
    endgenerate

    // Round-robin search: first pending index upward from last+1, wrapping
    logic [IDX_W-1:0]       win_idx;
    logic                   win_found;
    logic [IDX_W:0]         cand_ext;
    logic [IDX_W-1:0]       cand_idx;

    // Winner selection starting just past the previous owner
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand_ext  = '0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_ext = {1'b0, last_reg} + (IDX_W+1)'(k);
            if (cand_ext >= (IDX_W+1)'(NUM_REQ)) begin
                cand_ext = cand_ext - (IDX_W+1)'(NUM_REQ);
            end
            cand_idx = cand_ext[IDX_W-1:0];
            if (!win_found && pending[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Watchdog: timeout_hit asks the FSM to complete as if ready arrived
    logic timeout_hit;

`ifdef HL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Count BUSY cycles; any other state leaves it at 0 for the next entry
    always_comb begin
        cnt_next = '0;
        if (state_reg == BUSY) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk_h) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign timeout_hit = (state_reg == BUSY) &&
                         (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and output logic; every register holds unless changed
    always_comb begin
        state_next      = state_reg;
        last_next       = last_reg;
        grant_next      = grant_reg;
        data_ready_next = '0;
        data_out_next   = data_out_reg;
        h_read_en_next  = h_read_en_reg;
        h_write_en_next = h_write_en_reg;
        h_addr_next     = h_addr_reg;
        h_data_in_next  = h_data_in_reg;
        timeout_next    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                h_read_en_next  = 1'b0;
                h_write_en_next = 1'b0;
                if (win_found) begin
                    grant_next          = '0;
                    grant_next[win_idx] = 1'b1;
                    h_addr_next         = addr_arr[win_idx];
                    h_data_in_next      = wdata_arr[win_idx];
                    // Write wins when a requester raises both enables
                    h_write_en_next     = bus.req_write_en[win_idx];
                    h_read_en_next      = bus.req_read_en[win_idx] &
                                          ~bus.req_write_en[win_idx];
                    last_next           = win_idx;
                    state_next          = BUSY;
                end
            end

            BUSY: begin
                // Requester inputs are ignored here; the latched copy drives h_*
                if (bus.h_data_ready || timeout_hit) begin
                    h_read_en_next  = 1'b0;
                    h_write_en_next = 1'b0;
                    data_out_next   = bus.h_data_ready ? bus.h_data_out : {WIDTH{1'b1}};
                    data_ready_next = grant_reg;
                    timeout_next    = ~bus.h_data_ready;
                    state_next      = RELEASE;
                end
            end

            RELEASE: begin
                grant_next     = '0;
                h_addr_next    = '0;
                h_data_in_next = '0;
                state_next     = IDLE;
            end

            default: begin
                grant_next      = '0;
                h_read_en_next  = 1'b0;
                h_write_en_next = 1'b0;
                h_addr_next     = '0;
                h_data_in_next  = '0;
                state_next      = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any outstanding transaction
    always_ff @(posedge clk_h) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_reg       <= IDX_W'(NUM_REQ - 1);
            grant_reg      <= '0;
            data_ready_reg <= '0;
            data_out_reg   <= '0;
            h_read_en_reg  <= 1'b0;
            h_write_en_reg <= 1'b0;
            h_addr_reg     <= '0;
            h_data_in_reg  <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_reg       <= last_next;
            grant_reg      <= grant_next;
            data_ready_reg <= data_ready_next;
            data_out_reg   <= data_out_next;
            h_read_en_reg  <= h_read_en_next;
            h_write_en_reg <= h_write_en_next;
            h_addr_reg     <= h_addr_next;
            h_data_in_reg  <= h_data_in_next;
            timeout_reg    <= timeout_next;
        end
    end

    assign bus.req_grant      = grant_reg;
    assign bus.req_data_ready = data_ready_reg;
    assign bus.req_data_out   = data_out_reg;
    assign bus.h_read_en      = h_read_en_reg;
    assign bus.h_write_en     = h_write_en_reg;
    assign bus.h_addr         = h_addr_reg;
    assign bus.h_data_in      = h_data_in_reg;
    assign bus.arb_timeout    = timeout_reg;

endmodule

// File: tb/tb_hl_bus_arbiter.sv
// Directed bench for hl_bus_arbiter: a table of complete transactions with
// hand-computed winners, plus hand-written sequences for request withdrawal,
// reset during BUSY and (when HL_ARB_TIMEOUT_EN is defined) the watchdog.
module tb_hl_bus_arbiter;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int AB = 31;
    localparam int NV = 13;

    logic clk_h = 1'b0;
    logic rst   = 1'b1;

    always #5 clk_h = ~clk_h;

    hl_bus_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .MAX_BIT_POS(AB)) bus ();

    hl_bus_arbiter #(
        .NUM_REQ(N), .WIDTH(W), .MAX_BIT_POS(AB), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_h(clk_h),
        .rst  (rst),
        .bus  (bus)
    );

    typedef struct {
        logic [N-1:0]         rd;
        logic [N-1:0]         wr;
        logic [N-1:0][31:0]   addr;
        logic [N-1:0][31:0]   wdata;
        int                   lat;      // cycles h_*_en stays high
        logic [31:0]          resp;     // adapter read data
        int                   exp_idx;  // expected winner
        logic                 exp_wr;   // expected write (else read)
    } vec_t;

    vec_t vt [NV];
    int   nv = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_h);
        #1;
    endtask

    task automatic add(input logic [N-1:0] rd, input logic [N-1:0] wr, input int lat,
                       input logic [31:0] resp, input int exp_idx, input logic exp_wr);
        vt[nv].rd      = rd;
        vt[nv].wr      = wr;
        vt[nv].lat     = lat;
        vt[nv].resp    = resp;
        vt[nv].exp_idx = exp_idx;
        vt[nv].exp_wr  = exp_wr;
        for (int i = 0; i < N; i++) begin
            vt[nv].addr[i]  = 32'h0001_0000 + (32'(nv) << 8) + (32'(i) << 4);
            vt[nv].wdata[i] = 32'hD000_0000 + (32'(nv) << 8) + 32'(i);
        end
        nv++;
    endtask

    task automatic drive_req(input logic [N-1:0] rd, input logic [N-1:0] wr,
                             input logic [N-1:0][31:0] addr, input logic [N-1:0][31:0] wdata);
        bus.req_read_en  = rd;
        bus.req_write_en = wr;
        bus.req_addr     = addr;
        bus.req_data_in  = wdata;
    endtask

    task automatic drop_req();
        bus.req_read_en  = '0;
        bus.req_write_en = '0;
    endtask

    logic [N-1:0]       exp_grant;
    logic [N-1:0][31:0] hs_addr;
    logic [N-1:0][31:0] hs_data;
    int                 en_cycles;

    initial begin
        // Table: after reset last=2, so the search starts at requester 0
        add(3'b111, 3'b000, 1, 32'h0000_1111, 0, 1'b0);
        add(3'b111, 3'b000, 2, 32'h0000_2222, 1, 1'b0);
        add(3'b111, 3'b000, 3, 32'h0000_3333, 2, 1'b0);
        add(3'b111, 3'b000, 1, 32'h0000_4444, 0, 1'b0);
        add(3'b111, 3'b000, 4, 32'h0000_5555, 1, 1'b0);
        add(3'b111, 3'b000, 2, 32'h0000_6666, 2, 1'b0);
        add(3'b010, 3'b000, 7, 32'h1234_5678, 1, 1'b0);
        add(3'b100, 3'b100, 3, 32'hDEAD_BEEF, 2, 1'b1);
        add(3'b101, 3'b000, 2, 32'h0BAD_F00D, 0, 1'b0);
        add(3'b101, 3'b000, 1, 32'h7777_0001, 2, 1'b0);
        add(3'b000, 3'b011, 2, 32'h8888_0002, 0, 1'b1);
        add(3'b010, 3'b001, 1, 32'h9999_0003, 1, 1'b0);
        add(3'b101, 3'b000, 3, 32'hAAAA_0004, 2, 1'b0);
        vt[6].addr[1]  = 32'h0000_0040;
        vt[7].wdata[2] = 32'hA5A5_0000;

        bus.req_read_en  = '0;
        bus.req_write_en = '0;
        bus.req_addr     = '0;
        bus.req_data_in  = '0;
        bus.h_data_ready = 1'b0;
        bus.h_data_out   = '0;
        rst = 1'b1;
        step();
        step();

        // Reset state
        check("rst_grant",      32'(bus.req_grant), 32'h0);
        check("rst_data_ready", 32'(bus.req_data_ready), 32'h0);
        check("rst_data_out",   bus.req_data_out, 32'h0);
        check("rst_h_read_en",  32'(bus.h_read_en), 32'h0);
        check("rst_h_write_en", 32'(bus.h_write_en), 32'h0);
        check("rst_h_addr",     bus.h_addr, 32'h0);
        check("rst_h_data_in",  bus.h_data_in, 32'h0);
        check("rst_timeout",    32'(bus.arb_timeout), 32'h0);
        rst = 1'b0;
        step();
        check("idle_no_grant",  32'(bus.req_grant), 32'h0);

        // Table-driven transactions
        for (int v = 0; v < NV; v++) begin
            drive_req(vt[v].rd, vt[v].wr, vt[v].addr, vt[v].wdata);
            bus.h_data_ready = 1'b0;
            step();
            exp_grant = N'(1) << vt[v].exp_idx;
            check("grant",      32'(bus.req_grant), 32'(exp_grant));
            check("h_read_en",  32'(bus.h_read_en), 32'(!vt[v].exp_wr));
            check("h_write_en", 32'(bus.h_write_en), 32'(vt[v].exp_wr));
            check("h_addr",     bus.h_addr, vt[v].addr[vt[v].exp_idx]);
            check("h_data_in",  bus.h_data_in, vt[v].wdata[vt[v].exp_idx]);
            check("early_ready", 32'(bus.req_data_ready), 32'h0);
            en_cycles = (bus.h_read_en | bus.h_write_en) ? 1 : 0;
            for (int c = 1; c < vt[v].lat; c++) begin
                step();
                if (bus.h_read_en | bus.h_write_en) en_cycles++;
            end
            check("grant_held", 32'(bus.req_grant), 32'(exp_grant));
            bus.h_data_ready = 1'b1;
            bus.h_data_out   = vt[v].resp;
            step();
            check("enable_cycles", 32'(en_cycles), 32'(vt[v].lat));
            check("en_low_at_done", 32'(bus.h_read_en | bus.h_write_en), 32'h0);
            check("data_ready",   32'(bus.req_data_ready), 32'(exp_grant));
            check("data_out",     bus.req_data_out, vt[v].resp);
            check("no_timeout",   32'(bus.arb_timeout), 32'h0);
            bus.h_data_ready = 1'b0;
            bus.h_data_out   = 32'h5A5A_5A5A;
            drop_req();
            step();
            check("rel_ready",  32'(bus.req_data_ready), 32'h0);
            check("rel_grant",  32'(bus.req_grant), 32'h0);
            check("rel_addr",   bus.h_addr, 32'h0);
            check("rel_data",   bus.h_data_in, 32'h0);
            $display("txn %0d: owner %0d %s addr=0x%08h wdata=0x%08h rdata=0x%08h lat=%0d",
                     v, vt[v].exp_idx, vt[v].exp_wr ? "write" : "read",
                     vt[v].addr[vt[v].exp_idx], vt[v].wdata[vt[v].exp_idx],
                     vt[v].resp, vt[v].lat);
        end

        // Owner withdraws its request two cycles into BUSY (last=2 -> req 0)
        hs_addr = '0;
        hs_data = '0;
        hs_addr[0] = 32'h0000_0080;
        drive_req(3'b001, 3'b000, hs_addr, hs_data);
        step();
        check("drop_grant", 32'(bus.req_grant), 32'h1);
        step();
        step();
        drop_req();
        for (int c = 0; c < 3; c++) begin
            step();
            check("drop_read_held", 32'(bus.h_read_en), 32'h1);
        end
        check("drop_grant_held", 32'(bus.req_grant), 32'h1);
        check("drop_addr_held",  bus.h_addr, 32'h0000_0080);
        bus.h_data_ready = 1'b1;
        bus.h_data_out   = 32'hCAFE_0001;
        step();
        check("drop_data_ready", 32'(bus.req_data_ready), 32'h1);
        check("drop_data_out",   bus.req_data_out, 32'hCAFE_0001);
        bus.h_data_ready = 1'b0;
        step();
        step();
        check("drop_no_regrant", 32'(bus.req_grant), 32'h0);
        $display("txn drop: owner 0 read addr=0x00000080 rdata=0xcafe0001 withdrawn in BUSY");

        // Reset during BUSY (last=0 -> req 1 granted)
        hs_addr[1] = 32'h0000_0C00;
        drive_req(3'b010, 3'b000, hs_addr, hs_data);
        step();
        check("rb_grant", 32'(bus.req_grant), 32'h2);
        step();
        step();
        rst = 1'b1;
        bus.h_data_ready = 1'b1;
        bus.h_data_out   = 32'hBEEF_0002;
        step();
        check("rb_grant_clr",   32'(bus.req_grant), 32'h0);
        check("rb_no_ready",    32'(bus.req_data_ready), 32'h0);
        check("rb_read_clr",    32'(bus.h_read_en), 32'h0);
        check("rb_addr_clr",    bus.h_addr, 32'h0);
        check("rb_data_out",    bus.req_data_out, 32'h0);
        rst = 1'b0;
        bus.h_data_ready = 1'b0;
        drive_req(3'b011, 3'b000, hs_addr, hs_data);
        step();
        check("rb_first_req0",  32'(bus.req_grant), 32'h1);
        check("rb_still_no_rdy", 32'(bus.req_data_ready), 32'h0);
        bus.h_data_ready = 1'b1;
        bus.h_data_out   = 32'h0000_00AB;
        step();
        check("rb_done", 32'(bus.req_data_ready), 32'h1);
        bus.h_data_ready = 1'b0;
        drop_req();
        step();
        step();
        $display("txn reset: owner 1 aborted by rst, then owner 0 read rdata=0x000000ab");

`ifdef HL_ARB_TIMEOUT_EN
        // Watchdog: adapter never ready (last=0 -> req 2 wins over req 0)
        drive_req(3'b101, 3'b000, hs_addr, hs_data);
        step();
        check("to_grant", 32'(bus.req_grant), 32'h4);
        for (int c = 0; c < 15; c++) begin
            step();
        end
        check("to_not_yet", 32'(bus.arb_timeout), 32'h0);
        check("to_busy_ready", 32'(bus.req_data_ready), 32'h0);
        step();
        check("to_pulse",      32'(bus.arb_timeout), 32'h1);
        check("to_data_ready", 32'(bus.req_data_ready), 32'h4);
        check("to_data_out",   bus.req_data_out, 32'hFFFF_FFFF);
        drive_req(3'b001, 3'b000, hs_addr, hs_data);
        step();
        check("to_pulse_end", 32'(bus.arb_timeout), 32'h0);
        step();
        check("to_next_grant", 32'(bus.req_grant), 32'h1);
        bus.h_data_ready = 1'b1;
        step();
        bus.h_data_ready = 1'b0;
        drop_req();
        step();
        step();
        $display("txn timeout: owner 2 aborted by watchdog, owner 0 granted next");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
